dac_spi_tx: RTL and testbench

- Downstream stage of the voice output mux: serializes each selected 12-bit DDS sample into a 16-bit SPI frame for an external 12-bit DAC (DAC121S101-style format).
- One frame per `load` strobe, normally the divided sample-rate enable.
- Replaces direct parallel drive of the output pins with three pins: `sclk`, `mosi`, `csb`.

---
 rtl/dac_spi_tx_pkg.sv | 17 +
 rtl/dac_spi_if.sv | 22 ++
 rtl/dac_spi_tick.sv | 16 +
 rtl/dac_spi_tx.sv | 82 ++++++++
 tb/tb_dac_spi_tx.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dac_spi_tx_pkg.sv
// dac_spi_tx_pkg: shared state encodings, power-down codes and frame defaults
package dac_spi_tx_pkg;
  localparam int DATA_W_DEF = 12;
  localparam int FRAME_W_DEF = 16;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;
  typedef enum logic [1:0] {
    PD_NORMAL = 2'b00,
    PD_1K     = 2'b01,
    PD_100K   = 2'b10,
    PD_HIZ    = 2'b11
  } power_t;
endpackage

// File: rtl/dac_spi_if.sv
// dac_spi_if: sample strobe from the voice mux plus the SPI pins and status of dac_spi_tx
interface dac_spi_if import dac_spi_tx_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF
);
  logic load;
  logic [DATA_W-1:0] sample;
  power_t power_state;
  logic sclk;
  logic mosi;
  logic csb;
  logic busy;
  logic done;
  logic [7:0] overrun_cnt;
  modport master (
    output load, sample, power_state,
    input sclk, mosi, csb, busy, done, overrun_cnt
  );
  modport slave (
    input load, sample, power_state,
    output sclk, mosi, csb, busy, done, overrun_cnt
  );
endinterface

// File: rtl/dac_spi_tick.sv
// dac_spi_tick: one-cycle strobe on the last clk of every SCLK half-period
module dac_spi_tick #(
  parameter int CLK_DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  logic [7:0] cnt;
  assign tick = !clr && cnt == 8'd0;
  // Reload on clear or at each boundary so every half-period lasts CLK_DIV cycles
  always_ff @(posedge clk) begin
    cnt <= (rst || clr || cnt == 8'd0) ? 8'(CLK_DIV - 1) : cnt - 8'd1;
  end
endmodule

// File: rtl/dac_spi_tx.sv
// dac_spi_tx: serializes each DAC sample into a 16-bit SPI frame {00, power_state, sample}
module dac_spi_tx import dac_spi_tx_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int FRAME_W = FRAME_W_DEF,
  parameter int CLK_DIV = 1,
  parameter int CSB_HIGH = 1
) (
  input logic clk,
  input logic rst,
  dac_spi_if.slave bus
);
  localparam int HW = $clog2(CSB_HIGH + 1);
  state_t state;
  logic tick;
  logic [FRAME_W-1:0] sh;
  logic [4:0] bit_cnt;
  logic [HW-1:0] hold_cnt;
  dac_spi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk(clk),
    .rst(rst),
    .clr(state == IDLE || state == HOLD),
    .tick(tick)
  );
  // Frame sequencer: every pin is registered together with the state it belongs to
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sh <= '0;
      bit_cnt <= '0;
      hold_cnt <= '0;
      bus.csb <= 1'b1;
      bus.sclk <= 1'b1;
      bus.mosi <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.overrun_cnt <= '0;
    end else begin
      bus.done <= 1'b0;
      if (bus.load && state != IDLE && bus.overrun_cnt != 8'hFF)
        bus.overrun_cnt <= bus.overrun_cnt + 8'd1;
      case (state)
        IDLE: if (bus.load) begin
          state <= SETUP;
          sh <= {2'b00, bus.power_state, bus.sample};
          bus.mosi <= 1'b0;
          bus.csb <= 1'b0;
          bus.busy <= 1'b1;
        end
        SETUP: if (tick) begin
          state <= SHIFT;
          bus.sclk <= 1'b0;
          bit_cnt <= '0;
        end
        SHIFT: if (tick) begin
          if (bit_cnt == 5'd31) begin
            state <= HOLD;
            bit_cnt <= '0;
            hold_cnt <= HW'(CSB_HIGH - 1);
            bus.csb <= 1'b1;
            bus.sclk <= 1'b1;
            bus.mosi <= 1'b0;
            bus.done <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 5'd1;
            bus.sclk <= ~bit_cnt[0];
            if (!bit_cnt[0] && bit_cnt != 5'd30) begin
              bus.mosi <= sh[FRAME_W-2];
              sh <= sh << 1;
            end
          end
        end
        HOLD: if (hold_cnt == '0) begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end else begin
          hold_cnt <= hold_cnt - HW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dac_spi_tx.sv
// tb_dac_spi_tx: scoreboard bench for two transmitters (CLK_DIV 1 and 3)
module tb_dac_spi_tx;
  import dac_spi_tx_pkg::*;
  localparam int CSB_HIGH = 1;
  typedef struct {
    logic [15:0] frame;
    int gap;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load [2] = '{1'b0, 1'b0};
  logic [11:0] sample [2] = '{12'd0, 12'd0};
  logic [1:0] pwr [2] = '{2'd0, 2'd0};
  logic sclk [2];
  logic mosi [2];
  logic csb [2];
  logic busy [2];
  logic done [2];
  logic [7:0] ovr [2];
  exp_t exp_q [2][$];
  int left [2] = '{0, 0};
  int ovr_m [2] = '{0, 0};
  int last_acc [2] = '{-1, -1};
  int cyc_n = 0;
  int n_cmp = 0;
  int n_bad = 0;
  logic fin_req = 1'b0;
  logic fin_done = 1'b0;
  logic prev_csb [2] = '{1'b1, 1'b1};
  logic prev_sclk [2] = '{1'b1, 1'b1};
  logic prev_mosi [2] = '{1'b0, 1'b0};
  int nb [2] = '{0, 0};
  int low_len [2] = '{0, 0};
  int run [2] = '{0, 0};
  int hl [2] = '{0, 0};
  logic [15:0] word [2] = '{16'd0, 16'd0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gi
    dac_spi_if bus ();
    assign bus.load = load[g];
    assign bus.sample = sample[g];
    assign bus.power_state = power_t'(pwr[g]);
    assign sclk[g] = bus.sclk;
    assign mosi[g] = bus.mosi;
    assign csb[g] = bus.csb;
    assign busy[g] = bus.busy;
    assign done[g] = bus.done;
    assign ovr[g] = bus.overrun_cnt;
    dac_spi_tx #(.CLK_DIV(g == 0 ? 1 : 3), .CSB_HIGH(CSB_HIGH)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
  end

  function automatic int div_of(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  function automatic void chk(input string nm, input int g, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h, expected %0h", nm, g, act, exp);
    end
  endfunction

  // Reference model: a frame occupies the transmitter for 33*CLK_DIV+CSB_HIGH edges after acceptance
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc_n++;
      for (int g = 0; g < 2; g++) begin
        if (rst) begin
          left[g] = 0;
          ovr_m[g] = 0;
          last_acc[g] = -1;
          exp_q[g].delete();
        end else if (left[g] > 0) begin
          left[g]--;
          if (load[g]) ovr_m[g] = (ovr_m[g] == 255) ? 255 : ovr_m[g] + 1;
        end else if (load[g]) begin
          e.frame = {2'b00, pwr[g], sample[g]};
          e.gap = (last_acc[g] < 0) ? -1 : cyc_n - last_acc[g] - 33 * div_of(g);
          exp_q[g].push_back(e);
          left[g] = 33 * div_of(g) + CSB_HIGH;
          last_acc[g] = cyc_n;
        end
      end
    end
  end

  // Monitor: decodes the SPI pins on the falling clk edge and checks them against the model
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (rst) begin
          chk("rst_csb", g, csb[g], 1);
          chk("rst_sclk", g, sclk[g], 1);
          chk("rst_mosi", g, mosi[g], 0);
          chk("rst_busy", g, busy[g], 0);
          chk("rst_done", g, done[g], 0);
          chk("rst_overrun_cnt", g, ovr[g], 0);
          prev_csb[g] = 1'b1;
          hl[g] = 0;
        end else begin
          chk("busy", g, busy[g], left[g] > 0);
          chk("done", g, done[g], left[g] == CSB_HIGH);
          chk("overrun_cnt", g, ovr[g], ovr_m[g]);
          if (prev_csb[g] && !csb[g]) begin
            chk("frame_expected", g, exp_q[g].size() > 0, 1);
            if (exp_q[g].size() > 0 && exp_q[g][0].gap >= 0)
              chk("csb_high_gap", g, hl[g], exp_q[g][0].gap);
            nb[g] = 0;
            word[g] = '0;
            low_len[g] = 0;
            run[g] = 0;
            prev_sclk[g] = 1'b1;
          end
          if (!csb[g]) begin
            low_len[g]++;
            if (sclk[g] != prev_sclk[g]) begin
              chk("sclk_phase", g, run[g], div_of(g));
              run[g] = 1;
            end else begin
              run[g]++;
            end
            if (prev_sclk[g] && !sclk[g]) begin
              word[g] = {word[g][14:0], prev_mosi[g]};
              nb[g]++;
            end
            prev_sclk[g] = sclk[g];
          end else begin
            chk("idle_sclk", g, sclk[g], 1);
            chk("idle_mosi", g, mosi[g], 0);
            if (!prev_csb[g]) begin
              chk("last_phase", g, run[g], div_of(g));
              chk("csb_low_len", g, low_len[g], 33 * div_of(g));
              chk("bit_count", g, nb[g], 16);
              chk("frame_queued", g, exp_q[g].size() > 0, 1);
              if (exp_q[g].size() > 0) begin
                e = exp_q[g].pop_front();
                chk("frame_word", g, word[g], e.frame);
              end
              hl[g] = 1;
            end else begin
              hl[g]++;
            end
          end
          prev_csb[g] = csb[g];
        end
        prev_mosi[g] = mosi[g];
      end
      if (fin_req && !fin_done) begin
        chk("leftover_frames", 0, exp_q[0].size(), 0);
        chk("leftover_frames", 1, exp_q[1].size(), 0);
        fin_done = 1'b1;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic arm(input int g);
    load[g] = 1'b1;
    sample[g] = 12'($urandom);
    pwr[g] = 2'($urandom);
  endtask

  task automatic pulse(input int g, input logic [11:0] s, input logic [1:0] p);
    load[g] = 1'b1;
    sample[g] = s;
    pwr[g] = p;
    cyc(1);
    load[g] = 1'b0;
  endtask

  // Stimulus: directed frames, back-to-back, overrun, resets, saturation, then random traffic
  initial begin
    cyc(3);
    rst = 1'b0;
    cyc(2);
    pulse(0, 12'hA5C, 2'b00);
    cyc(40);
    pulse(1, 12'h001, 2'b11);
    cyc(110);
    repeat (3) begin
      pulse(0, 12'($urandom), 2'($urandom));
      cyc(33 + CSB_HIGH);
    end
    cyc(40);
    repeat (2) begin
      pulse(1, 12'($urandom), 2'($urandom));
      cyc(99 + CSB_HIGH);
    end
    cyc(20);
    for (int i = 0; i < 40; i++) begin
      arm(0);
      arm(1);
      cyc(1);
      load[0] = 1'b0;
      load[1] = 1'b0;
      cyc(9);
    end
    cyc(110);
    pulse(0, 12'($urandom), 2'($urandom));
    cyc(16);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    cyc(3);
    pulse(0, 12'hFFF, 2'b00);
    cyc(40);
    rst = 1'b1;
    load[0] = 1'b1;
    load[1] = 1'b1;
    cyc(1);
    rst = 1'b0;
    load[0] = 1'b0;
    load[1] = 1'b0;
    cyc(40);
    for (int i = 0; i < 300; i++) begin
      arm(0);
      cyc(1);
    end
    load[0] = 1'b0;
    cyc(40);
    for (int i = 0; i < 800; i++) begin
      for (int g = 0; g < 2; g++) begin
        load[g] = 1'b0;
        if ($urandom_range(0, 19) == 0) arm(g);
      end
      cyc(1);
    end
    load[0] = 1'b0;
    load[1] = 1'b0;
    cyc(120);
    fin_req = 1'b1;
    for (int i = 0; i < 20 && !fin_done; i++) cyc(1);
    if (!fin_done) begin
      $display("FAIL monitor_finish: got no acknowledge, expected one within 20 cycles");
      $fatal(1, "monitor stalled");
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
